sys_time_keeper: RTL and testbench
==================================

Name: sys_time_keeper

Overview:
- Free-running system-time counter and timestamp arbiter, placed downstream of the host time-register decoder on trn_clk.
- Loads nanoseconds/seconds whenever the host rewrites them, then advances time every clock with carry into seconds.
- Serves timestamp snapshots to two requesters (0 = RX path, 1 = TX path) under round-robin arbitration.
- Honours the host RX-timestamp enable.

Parameters:
- NS_PER_CLK, 4, nanoseconds added per trn_clk cycle (250 MHz).
- NS_WRAP, 1000000000, nanosecond rollover value.

Ports:
- trn_clk  in  1  system/PCIe user clock
- reset_n  in  1  asynchronous active-low reset
- sys_nsecs  in  32  host-written nanoseconds (held value)
- sys_secs  in  32  host-written seconds (held value)
- rx_timestamp_en  in  1  host RX timestamp enable
- ts_req  in  2  level request per requester; held until granted
- ts_gnt  out  2  one-cycle grant pulse, one-hot or zero
- ts_value  out  64  {secs, nsecs} snapshot, valid while ts_gnt != 0
- cur_nsecs  out  32  running nanoseconds
- cur_secs  out  32  running seconds
- pps  out  1  one-cycle pulse on each seconds carry

Behaviour:
- Clock and reset: one clock, trn_clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0. Internal prev_nsecs/prev_secs = 0, last_gnt = 1 (so requester 0 wins first), FSM = IDLE.
- Load detection:
  - prev_* registers sample sys_nsecs/sys_secs every cycle.
  - A field is loaded in the cycle after its input differs from prev_*: cur_* <= input value, no increment that cycle.
  - Each field loads independently.
- Nanosecond load clamp: a loaded nsecs >= NS_WRAP is stored as 0; seconds are unaffected.
- Increment (cycles without an nsecs load):
  - n = cur_nsecs + NS_PER_CLK, evaluated in 33 bits.
  - If n >= NS_WRAP: cur_nsecs <= n - NS_WRAP, cur_secs <= cur_secs + 1 (mod 2^32, 0xFFFFFFFF wraps to 0), and pps = 1 for that cycle.
  - Otherwise cur_nsecs <= n.
- Load/carry priority:
  - A secs load in the same cycle as a carry: the load wins and the carry is dropped. pps still pulses if the nsecs carry occurred.
  - An nsecs load suppresses both the increment and the carry.
- Arbiter FSM:
  - IDLE: if ts_req != 0, pick the requester that is not last_gnt when both request, else the single requester. Go to GRANT.
  - GRANT: assert ts_gnt[i] for exactly one cycle, update last_gnt = i, return to IDLE. At most one grant every 2 cycles; a requester drops ts_req in the cycle after its grant.
- Snapshot: ts_value = {cur_secs, cur_nsecs} registered on IDLE->GRANT. Latency is 1 cycle from the request being sampled to the grant.
- RX disable: if requester 0 is granted while rx_timestamp_en = 0, ts_value = 64'h0 (the grant still occurs so RX never stalls).
- ts_value is held between grants; it is meaningful only when ts_gnt != 0.
- Reset mid-grant: ts_gnt clears asynchronously; the request is re-arbitrated after reset releases.

Decomposition:
- Shared package/include holds: NS_WRAP default, FSM state encodings (IDLE, GRANT), and the requester index constants (REQ_RX = 0, REQ_TX = 1).
- One natural sub-module: sys_time_counter (load detection, increment, carry, pps). The arbiter stays in the top.

Test Plan:
- Reset, then release with no host writes -> after 10 cycles cur_nsecs = 40, cur_secs = 0, ts_gnt = 0.
- sys_nsecs changed to 999999996 -> one cycle after load, cur_nsecs = 0, cur_secs = 1, pps pulses once.
- sys_secs changed to 0xFFFFFFFF and sys_nsecs to 999999996 -> after carry, cur_secs = 0, cur_nsecs = 0.
- ts_req = 2'b11 held continuously (each requester re-raises after its grant) -> grants alternate 01, 10, 01 on every other cycle. Each ts_value equals the counter at the grant, and successive ts_value differ by 8 ns.
- rx_timestamp_en = 0 with ts_req = 2'b01 -> ts_gnt = 01 and ts_value = 0. Set rx_timestamp_en = 1 and repeat -> ts_value is nonzero.
- sys_nsecs written as 1200000000 -> cur_nsecs = 0 the following cycle, cur_secs unchanged, no pps.

Source files
------------

// File: rtl/sys_time_keeper_pkg.sv
// Shared constants and types for the system-time keeper.
// Holds the rollover value, the arbiter states and the requester indices.
package sys_time_keeper_pkg;

    localparam int unsigned NS_PER_CLK_DEF = 4;
    localparam int unsigned NS_WRAP_DEF    = 1000000000;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic REQ_RX = 1'b0;
    localparam logic REQ_TX = 1'b1;

    typedef struct packed {
        logic [31:0] secs;
        logic [31:0] nsecs;
    } tstamp_t;

endpackage

// File: rtl/sys_time_counter.sv
// Running {secs, nsecs} counter: loads host rewrites, otherwise advances every clock.
// Latency: a host rewrite appears 1 cycle after the change. pps is registered with the carry.
// Backpressure: none, the counter free-runs.
module sys_time_counter
    import sys_time_keeper_pkg::*;
#(
    parameter int unsigned NS_PER_CLK = NS_PER_CLK_DEF,
    parameter int unsigned NS_WRAP    = NS_WRAP_DEF
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [31:0] sys_nsecs,
    input  logic [31:0] sys_secs,
    output logic [31:0] cur_nsecs,
    output logic [31:0] cur_secs,
    output logic        pps
);

    logic [31:0] prev_nsecs;
    logic [31:0] prev_secs;
    logic        nsecs_load;
    logic        secs_load;
    logic [32:0] ns_sum;
    logic        carry;
    logic [31:0] nsecs_next;
    logic [31:0] secs_next;

    assign nsecs_load = (sys_nsecs != prev_nsecs);
    assign secs_load  = (sys_secs != prev_secs);
    assign ns_sum     = {1'b0, cur_nsecs} + 33'(NS_PER_CLK);
    // An nsecs load replaces the increment, so it also swallows any carry.
    assign carry      = !nsecs_load && (ns_sum >= 33'(NS_WRAP));

    always_comb begin
        nsecs_next = ns_sum[31:0];
        if (nsecs_load) begin
            nsecs_next = (sys_nsecs >= 32'(NS_WRAP)) ? 32'd0 : sys_nsecs;
        end else if (carry) begin
            nsecs_next = 32'(ns_sum - 33'(NS_WRAP));
        end

        secs_next = cur_secs;
        if (secs_load) begin
            secs_next = sys_secs;
        end else if (carry) begin
            secs_next = cur_secs + 32'd1;
        end
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_nsecs <= '0;
            prev_secs  <= '0;
            cur_nsecs  <= '0;
            cur_secs   <= '0;
            pps        <= 1'b0;
        end else begin
            prev_nsecs <= sys_nsecs;
            prev_secs  <= sys_secs;
            cur_nsecs  <= nsecs_next;
            cur_secs   <= secs_next;
            pps        <= carry;
        end
    end

endmodule

// File: rtl/sys_time_keeper.sv
// System-time counter plus round-robin timestamp arbiter for the RX and TX paths.
// Latency: grant 1 cycle after the request is sampled. At most one grant every 2 cycles.
// Backpressure: requesters hold ts_req until granted. RX is granted even when disabled.
module sys_time_keeper
    import sys_time_keeper_pkg::*;
#(
    parameter int unsigned NS_PER_CLK = NS_PER_CLK_DEF,
    parameter int unsigned NS_WRAP    = NS_WRAP_DEF
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [31:0] sys_nsecs,
    input  logic [31:0] sys_secs,
    input  logic        rx_timestamp_en,
    input  logic [1:0]  ts_req,
    output logic [1:0]  ts_gnt,
    output logic [63:0] ts_value,
    output logic [31:0] cur_nsecs,
    output logic [31:0] cur_secs,
    output logic        pps
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_gnt;
    logic       gnt_idx;
    logic       pick_idx;
    tstamp_t    snap;

    sys_time_counter #(
        .NS_PER_CLK (NS_PER_CLK),
        .NS_WRAP    (NS_WRAP)
    ) u_counter (
        .trn_clk   (trn_clk),
        .reset_n   (reset_n),
        .sys_nsecs (sys_nsecs),
        .sys_secs  (sys_secs),
        .cur_nsecs (cur_nsecs),
        .cur_secs  (cur_secs),
        .pps       (pps)
    );

    always_comb begin
        state_next = state;
        // Contention goes to whoever was not served last; otherwise the sole requester.
        pick_idx   = (&ts_req) ? ~last_gnt : ts_req[1];
        case (state)
            IDLE:    if (|ts_req) state_next = GRANT;
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_idx  <= 1'b0;
            snap     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && |ts_req) begin
                gnt_idx <= pick_idx;
                if (pick_idx == REQ_RX && !rx_timestamp_en) begin
                    snap <= '0;
                end else begin
                    snap <= '{secs: cur_secs, nsecs: cur_nsecs};
                end
            end
            if (state == GRANT) begin
                last_gnt <= gnt_idx;
            end
        end
    end

    assign ts_gnt   = (state != GRANT)     ? 2'b00 :
                      (gnt_idx == REQ_TX)  ? 2'b10 : 2'b01;
    assign ts_value = snap;

endmodule

// File: tb/tb_sys_time_keeper.sv
// Randomized bench for sys_time_keeper against a total-nanoseconds reference model.
module tb_sys_time_keeper;

    localparam logic [63:0] WRAP = 64'd1000000000;

    logic        trn_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sys_nsecs = '0;
    logic [31:0] sys_secs = '0;
    logic        rx_timestamp_en = 1'b1;
    logic [1:0]  ts_req = 2'b00;
    logic [1:0]  ts_gnt;
    logic [63:0] ts_value;
    logic [31:0] cur_nsecs;
    logic [31:0] cur_secs;
    logic        pps;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_ns, m_s, m_host_ns, m_host_s;
    logic        m_pps, m_last;
    logic [1:0]  m_gnt;
    logic [63:0] m_ts;

    sys_time_keeper dut (
        .trn_clk         (trn_clk),
        .reset_n         (reset_n),
        .sys_nsecs       (sys_nsecs),
        .sys_secs        (sys_secs),
        .rx_timestamp_en (rx_timestamp_en),
        .ts_req          (ts_req),
        .ts_gnt          (ts_gnt),
        .ts_value        (ts_value),
        .cur_nsecs       (cur_nsecs),
        .cur_secs        (cur_secs),
        .pps             (pps)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ns = '0; m_s = '0; m_host_ns = '0; m_host_s = '0;
        m_pps = 1'b0; m_last = 1'b1; m_gnt = 2'b00; m_ts = '0;
    endtask

    // One clock edge of the specified behaviour, evaluated on the pre-edge inputs.
    task automatic model_edge();
        logic [63:0] total, new_secs;
        logic        served;
        // arbiter: snapshot uses the time shown before the edge
        if (m_gnt != 2'b00) begin
            m_last = m_gnt[1];
            m_gnt  = 2'b00;
        end else if (ts_req != 2'b00) begin
            served = (ts_req == 2'b11) ? !m_last : ts_req[1];
            m_gnt  = served ? 2'b10 : 2'b01;
            m_ts   = (!served && !rx_timestamp_en) ? 64'h0 : {m_s, m_ns};
        end
        // time: host rewrite wins, else advance the absolute nanosecond count
        m_pps = 1'b0;
        if (sys_nsecs != m_host_ns) begin
            m_ns = ({32'h0, sys_nsecs} >= WRAP) ? 32'h0 : sys_nsecs;
            if (sys_secs != m_host_s) m_s = sys_secs;
        end else begin
            total    = {32'h0, m_s} * WRAP + {32'h0, m_ns} + 64'd4;
            new_secs = total / WRAP;
            m_ns     = 32'(total % WRAP);
            m_pps    = (new_secs != {32'h0, m_s});
            m_s      = (sys_secs != m_host_s) ? sys_secs : new_secs[31:0];
        end
        m_host_ns = sys_nsecs;
        m_host_s  = sys_secs;
    endtask

    task automatic step();
        @(posedge trn_clk);
        model_edge();
        #1;
        check_val("gnt", ts_gnt, m_gnt);
        if (m_gnt != 2'b00) check_val("ts_value", ts_value, m_ts);
        check_val("nsecs", cur_nsecs, m_ns);
        check_val("secs", cur_secs, m_s);
        check_val("pps", pps, m_pps);
    endtask

    task automatic request_once(input logic [1:0] r, output logic [63:0] ts);
        bit got = 0;
        ts = '0;
        ts_req = r;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            if (ts_gnt != 2'b00) begin
                got = 1;
                ts = ts_value;
                check_val("single_gnt", ts_gnt, r);
            end
        end
        ts_req = 2'b00;
        if (!got) check_val("grant_timeout", 0, 1);
        step();
    endtask

    initial begin
        logic [63:0] ts, prev_ts;
        logic [1:0]  prev_gnt;
        logic [31:0] secs_before;
        int          ngnt;

        model_reset();
        repeat (3) @(posedge trn_clk);
        #1;
        check_val("rst_gnt", ts_gnt, 2'b00);
        check_val("rst_ts", ts_value, 64'h0);
        check_val("rst_nsecs", cur_nsecs, 0);
        check_val("rst_secs", cur_secs, 0);
        check_val("rst_pps", pps, 0);
        reset_n = 1'b1;

        repeat (10) step();
        check_val("free_run_40", cur_nsecs, 40);
        check_val("free_run_secs", cur_secs, 0);

        // nanosecond load right before rollover
        sys_nsecs = 32'd999999996;
        step();
        step();
        check_val("carry_nsecs", cur_nsecs, 0);
        check_val("carry_secs", cur_secs, 1);
        check_val("carry_pps", pps, 1);
        step();
        check_val("pps_once", pps, 0);

        // seconds wrap at 2^32
        sys_nsecs = 32'd0;
        step();
        sys_secs  = 32'hFFFF_FFFF;
        sys_nsecs = 32'd999999996;
        step();
        step();
        check_val("wrap_secs", cur_secs, 0);
        check_val("wrap_nsecs", cur_nsecs, 0);

        // round robin with both requesters always asking
        ts_req = 2'b11;
        ngnt = 0;
        prev_gnt = 2'b10;
        prev_ts = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ts_gnt != 2'b00) begin
                check_val("rr_alternate", ts_gnt, prev_gnt ^ 2'b11);
                if (ngnt > 0) check_val("rr_delta8", ts_value - prev_ts, 64'd8);
                prev_gnt = ts_gnt;
                prev_ts  = ts_value;
                ngnt++;
            end
        end
        check_val("rr_grant_count", ngnt, 6);
        ts_req = 2'b00;
        step();

        // RX timestamp enable
        rx_timestamp_en = 1'b0;
        request_once(2'b01, ts);
        check_val("rx_off_zero", ts, 64'h0);
        rx_timestamp_en = 1'b1;
        request_once(2'b01, ts);
        check_val("rx_on_nonzero", ts != 64'h0, 1);

        // out-of-range nanosecond write clamps to zero
        secs_before = cur_secs;
        sys_nsecs = 32'd1200000000;
        step();
        check_val("clamp_nsecs", cur_nsecs, 0);
        check_val("clamp_secs", cur_secs, secs_before);
        check_val("clamp_pps", pps, 0);

        // randomized traffic, with one reset landing on a grant
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(63, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0: sys_nsecs = $urandom_range(999999999, 999999900);
                    1: sys_nsecs = 32'd1000000000 + $urandom_range(5000, 0);
                    default: sys_nsecs = $urandom % 32'd1000000000;
                endcase
            end
            if ($urandom_range(127, 0) == 0)
                sys_secs = ($urandom_range(1, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(31, 0) == 0) rx_timestamp_en = ~rx_timestamp_en;
            for (int r = 0; r < 2; r++)
                if (!ts_req[r] && $urandom_range(2, 0) == 0) ts_req[r] = 1'b1;
            step();
            if (cyc >= 1500 && cyc < 1600 && m_gnt != 2'b00) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_async_gnt", ts_gnt, 2'b00);
                check_val("rst_async_nsecs", cur_nsecs, 0);
                model_reset();
                @(posedge trn_clk);
                #1;
                check_val("rst_hold_pps", pps, 0);
                reset_n = 1'b1;
                cyc = 1600;
            end else begin
                ts_req = ts_req & ~m_gnt;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
